// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: two-port round-robin arbiter and access sequencer in front of a direct-mapped cache.
// Latency: a write or read hit responds 2 edges after accept; each read miss adds FILL + retry (2 edges).
// Backpressure: one request in flight; only the granted port sees ready, and only in IDLE; rsp strobes cannot be stalled.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   reqN_valid/ready/addr/we/wdata   requester handshakes, port 0 = instruction, port 1 = data
//   rspN_valid/rdata/err        one-cycle response strobes (write echoes wdata, error returns 0)
//   cache_address/is_write/write_data, cache_hit/read_data   single cache port
//   busy                        FSM not in IDLE
//   stat_hits/stat_misses       first-lookup hit/miss counters (saturating)
// Optional: define CACHE_ARB_STATS_EN to build the statistic counters; otherwise they read as 0.
module cache_port_arbiter #(
   parameter int MAX_LOOKUPS = 2,
   parameter int STAT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [31:0]           req0_addr,
   input  logic                  req0_we,
   input  logic [31:0]           req0_wdata,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [31:0]           req1_addr,
   input  logic                  req1_we,
   input  logic [31:0]           req1_wdata,
   output logic                  rsp0_valid,
   output logic [31:0]           rsp0_rdata,
   output logic                  rsp0_err,
   output logic                  rsp1_valid,
   output logic [31:0]           rsp1_rdata,
   output logic                  rsp1_err,
   output logic [31:0]           cache_address,
   output logic                  cache_is_write,
   output logic [31:0]           cache_write_data,
   input  logic                  cache_hit,
   input  logic [31:0]           cache_read_data,
   output logic                  busy,
   output logic [STAT_WIDTH-1:0] stat_hits,
   output logic [STAT_WIDTH-1:0] stat_misses
);

   localparam int CW = (MAX_LOOKUPS < 1) ? 1 : $clog2(MAX_LOOKUPS + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LOOKUPS);

   typedef enum logic [1:0] {IDLE = 2'd0, LOOKUP = 2'd1, FILL = 2'd2, RESP = 2'd3} state_t;

   state_t        state, state_nxt;
   logic          ptr, port_q, we_q, err_q;
   logic [31:0]   addr_q, wdata_q, rdata_q;
   logic [CW-1:0] lookups_q, lookups_inc;
   logic          ptr_valid, other_valid, grant_any, grant_port, accept, last_lookup;

   // The pointer port wins a tie; the other port is only granted when the pointer port is idle.
   assign ptr_valid   = ptr ? req1_valid : req0_valid;
   assign other_valid = ptr ? req0_valid : req1_valid;
   assign grant_any   = ptr_valid | other_valid;
   assign grant_port  = ptr_valid ? ptr : ~ptr;
   assign lookups_inc = lookups_q + 1'b1;
   assign last_lookup = (lookups_inc == MAX_CNT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      accept         = 1'b0;
      req0_ready     = 1'b0;
      req1_ready     = 1'b0;
      cache_is_write = 1'b0;
      rsp0_valid     = 1'b0;
      rsp1_valid     = 1'b0;
      unique case (state)
         IDLE: begin
            // Ready is held low while reset is asserted so every output reads 0 in reset.
            if (grant_any && !reset) begin
               accept     = 1'b1;
               req0_ready = ~grant_port;
               req1_ready = grant_port;
               state_nxt  = LOOKUP;
            end
         end
         LOOKUP: begin
            cache_is_write = we_q;
            if (we_q || cache_hit || last_lookup) state_nxt = RESP;
            else                                  state_nxt = FILL;
         end
         FILL:    state_nxt = LOOKUP;
         RESP: begin
            rsp0_valid = ~port_q;
            rsp1_valid = port_q;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr       <= 1'b0;
         port_q    <= 1'b0;
         we_q      <= 1'b0;
         err_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         lookups_q <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  port_q    <= grant_port;
                  addr_q    <= grant_port ? req1_addr  : req0_addr;
                  we_q      <= grant_port ? req1_we    : req0_we;
                  wdata_q   <= grant_port ? req1_wdata : req0_wdata;
                  lookups_q <= '0;
               end
            end
            LOOKUP: begin
               if (we_q) begin
                  rdata_q <= wdata_q;
                  err_q   <= 1'b0;
               end else if (cache_hit) begin
                  rdata_q <= cache_read_data;
                  err_q   <= 1'b0;
               end else begin
                  // The cache refills on this same edge, so the retry after FILL should hit.
                  lookups_q <= lookups_inc;
                  if (last_lookup) begin
                     rdata_q <= '0;
                     err_q   <= 1'b1;
                  end
               end
            end
            RESP:    ptr <= ~ptr;
            default: ;
         endcase
      end
   end

   assign cache_address    = addr_q;
   assign cache_write_data = wdata_q;
   assign busy             = (state != IDLE);
   assign rsp0_rdata       = rsp0_valid ? rdata_q : '0;
   assign rsp1_rdata       = rsp1_valid ? rdata_q : '0;
   assign rsp0_err         = rsp0_valid & err_q;
   assign rsp1_err         = rsp1_valid & err_q;

`ifdef CACHE_ARB_STATS_EN
   // Only the first LOOKUP of a request is counted, writes included.
   logic first_lookup;
   assign first_lookup = (state == LOOKUP) && (lookups_q == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_hits   <= '0;
         stat_misses <= '0;
      end else if (first_lookup) begin
         if (cache_hit) begin
            if (stat_hits != '1) stat_hits <= stat_hits + 1'b1;
         end else begin
            if (stat_misses != '1) stat_misses <= stat_misses + 1'b1;
         end
      end
   end
`else
   assign stat_hits   = '0;
   assign stat_misses = '0;
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb_cache_port_arbiter: directed table, corner sequences and randomized traffic for cache_port_arbiter.
// Latency: n/a (bench).
// Backpressure: requesters hold valid until accepted; a small direct-mapped cache model answers lookups.
module tb_cache_port_arbiter;

   localparam int MAXL = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid = 1'b0, req0_we = 1'b0, req1_valid = 1'b0, req1_we = 1'b0;
   logic [31:0] req0_addr = '0, req0_wdata = '0, req1_addr = '0, req1_wdata = '0;
   logic        req0_ready, req1_ready, rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
   logic [31:0] rsp0_rdata, rsp1_rdata;
   logic [31:0] cache_address, cache_write_data, cache_read_data;
   logic        cache_is_write, cache_hit, busy;
   logic [15:0] stat_hits, stat_misses;

   always #5 clk = ~clk;

   cache_port_arbiter #(.MAX_LOOKUPS(MAXL), .STAT_WIDTH(16)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
      .req0_we(req0_we), .req0_wdata(req0_wdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
      .req1_we(req1_we), .req1_wdata(req1_wdata),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
      .cache_address(cache_address), .cache_is_write(cache_is_write),
      .cache_write_data(cache_write_data), .cache_hit(cache_hit),
      .cache_read_data(cache_read_data), .busy(busy),
      .stat_hits(stat_hits), .stat_misses(stat_misses));

   // ---------------- cache model: 16 lines, backing memory word = word index ----------------
   logic        line_v   [16] = '{default: 1'b0};
   logic [25:0] line_tag [16] = '{default: 26'd0};
   logic [31:0] line_dat [16] = '{default: 32'd0};
   logic [31:0] mem [logic [29:0]];
   logic        force_miss = 1'b0;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a[31:2])) return mem[a[31:2]];
      return {2'b00, a[31:2]};
   endfunction

   function automatic logic present(input logic [31:0] a);
      return !force_miss && line_v[a[5:2]] && (line_tag[a[5:2]] == a[31:6]);
   endfunction

   always_comb begin
      cache_hit       = present(cache_address);
      cache_read_data = line_dat[cache_address[5:2]];
   end

   always @(posedge clk) begin
      if (cache_is_write) begin
         mem[cache_address[31:2]] = cache_write_data;
         line_v[cache_address[5:2]]   <= 1'b1;
         line_tag[cache_address[5:2]] <= cache_address[31:6];
         line_dat[cache_address[5:2]] <= cache_write_data;
      end else if (busy && !cache_hit && !force_miss) begin
         line_v[cache_address[5:2]]   <= 1'b1;
         line_tag[cache_address[5:2]] <= cache_address[31:6];
         line_dat[cache_address[5:2]] <= mem_rd(cache_address);
      end
   end

   // ---------------- checking helpers ----------------
   int n_cmp = 0, n_fail = 0;
   int exp_hits = 0, exp_misses = 0;
   bit m_ptr = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] stat_exp(input int n);
`ifdef CACHE_ARB_STATS_EN
      return (n > 65535) ? 16'hFFFF : 16'(n);
`else
      return (n < 0) ? 16'hFFFF : 16'h0000;
`endif
   endfunction

   task automatic chk_stats(input string nm);
      chk({nm, "_hits"}, {16'h0, stat_hits}, {16'h0, stat_exp(exp_hits)});
      chk({nm, "_misses"}, {16'h0, stat_misses}, {16'h0, stat_exp(exp_misses)});
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_ctl"}, {24'h0, req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                          rsp0_err, rsp1_err, busy, cache_is_write}, 32'h0);
      chk({nm, "_rdata0"}, rsp0_rdata, 32'h0);
      chk({nm, "_rdata1"}, rsp1_rdata, 32'h0);
      chk({nm, "_caddr"}, cache_address, 32'h0);
      chk({nm, "_cwdata"}, cache_write_data, 32'h0);
      chk({nm, "_stats"}, {stat_hits, stat_misses}, 32'h0);
   endtask

   task automatic drive(input bit port, input bit v, input bit we, input logic [31:0] a, input logic [31:0] d);
      if (!port) begin
         req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
      end else begin
         req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
      end
   endtask

   task automatic do_reset(input string nm);
      @(negedge clk);
      drive(0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      reset = 1'b1;
      #1 chk_zero(nm);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      m_ptr = 1'b0; exp_hits = 0; exp_misses = 0;
   endtask

   // One request on one port; returns response fields, edges from accept to response, write-strobe cycles.
   task automatic do_req(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output bit err, output int lat, output int nwr);
      bit acc, got;
      rdata = '0; err = 1'b0; lat = 0; nwr = 0; acc = 1'b0; got = 1'b0;
      @(negedge clk);
      drive(port, 1, we, addr, wdata);
      for (int i = 0; i < 20 && !acc; i++) begin
         #1 acc = port ? req1_ready : req0_ready;
         @(posedge clk);
         if (!acc) @(negedge clk);
      end
      if (!acc) begin
         n_cmp++; n_fail++;
         $display("FAIL req_accept_timeout: port %0d never saw ready within 20 cycles", port);
         drive(port, 0, 0, 0, 0);
         return;
      end
      for (int i = 1; i <= 20 && !got; i++) begin
         @(negedge clk);
         if (i == 1) drive(port, 0, 0, 0, 0);
         #1;
         if (cache_is_write) nwr++;
         if (port ? rsp1_valid : rsp0_valid) begin
            got = 1'b1; lat = i;
            rdata = port ? rsp1_rdata : rsp0_rdata;
            err = port ? rsp1_err : rsp0_err;
         end
      end
      if (!got) begin
         n_cmp++; n_fail++;
         $display("FAIL rsp_timeout: port %0d got no response within 20 cycles", port);
      end else begin
         m_ptr = ~m_ptr;
      end
   endtask

   typedef struct {
      bit          port;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      bit          exp_err;
      int          exp_lat;
      bit          exp_hit;
   } vec_t;

   vec_t vecs [8];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rdata;
      bit          err;
      int          lat, nwr, ng, seen;
      bit          pend [2];
      bit          p_we [2];
      logic [31:0] p_addr [2], p_wdata [2];
      bit          m_busy, m_port, m_err, e_rsp, e_r0, e_r1, g, hit;
      logic [31:0] m_rdata;
      int          cyc, m_rsp_cyc, l;

      // port, we, addr, wdata, expected rdata, err, latency, first-lookup hit
      vecs[0] = '{0, 0, 32'h40,   32'h0,        32'h10,       0, 4, 0};
      vecs[1] = '{0, 0, 32'h40,   32'h0,        32'h10,       0, 2, 1};
      vecs[2] = '{1, 1, 32'h80,   32'hCAFE0001, 32'hCAFE0001, 0, 2, 0};
      vecs[3] = '{1, 0, 32'h80,   32'h0,        32'hCAFE0001, 0, 2, 1};
      vecs[4] = '{0, 0, 32'h40,   32'h0,        32'h10,       0, 4, 0};
      vecs[5] = '{1, 1, 32'h44,   32'h12345678, 32'h12345678, 0, 2, 0};
      vecs[6] = '{0, 0, 32'h44,   32'h0,        32'h12345678, 0, 2, 1};
      vecs[7] = '{1, 0, 32'h1000, 32'h0,        32'h400,      0, 4, 0};

      #1 chk_zero("reset0");
      do_reset("reset1");

      // ---------------- directed table ----------------
      for (int i = 0; i < 8; i++) begin
         do_req(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, rdata, err, lat, nwr);
         if (vecs[i].exp_hit) exp_hits++; else exp_misses++;
         chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
         chk($sformatf("vec%0d_err", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
         chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
         chk($sformatf("vec%0d_wr_cycles", i), nwr, vecs[i].we ? 1 : 0);
         chk_stats($sformatf("vec%0d", i));
      end

      // ---------------- every lookup misses: error after MAX_LOOKUPS ----------------
      force_miss = 1'b1;
      do_req(0, 0, 32'h40, 32'h0, rdata, err, lat, nwr);
      force_miss = 1'b0;
      exp_misses++;
      chk("err_rdata", rdata, 32'h0);
      chk("err_flag", {31'h0, err}, 32'h1);
      chk("err_latency", lat, 2 * MAXL);
      chk_stats("err");

      // ---------------- reset during FILL ----------------
      if (m_ptr == 1'b0) do_req(0, 0, 32'h44, 32'h0, rdata, err, lat, nwr);
      @(negedge clk);
      drive(1, 1, 0, 32'h2000, 32'h0);
      #1 chk("fill_grant_ptr_port", {31'h0, req1_ready}, 32'h1);
      @(posedge clk);
      @(negedge clk);
      drive(1, 0, 0, 0, 0);
      @(posedge clk);
      @(negedge clk);
      #1 chk("fill_busy", {31'h0, busy}, 32'h1);
      reset = 1'b1;
      #1 chk_zero("fill_rst");
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      m_ptr = 1'b0; exp_hits = 0; exp_misses = 0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1 if (rsp0_valid || rsp1_valid) seen++;
      end
      chk("fill_no_rsp", seen, 0);
      @(negedge clk);
      drive(0, 1, 0, 32'h40, 32'h0);
      drive(1, 1, 0, 32'h80, 32'h0);
      #1;
      chk("fill_after_r0", {31'h0, req0_ready}, 32'h1);
      chk("fill_after_r1", {31'h0, req1_ready}, 32'h0);

      // ---------------- both ports continuously valid ----------------
      do_reset("alt_rst");
      @(negedge clk);
      drive(0, 1, 0, 32'h40, 32'h0);
      drive(1, 1, 0, 32'h80, 32'h0);
      ng = 0;
      for (int i = 0; i < 60 && ng < 8; i++) begin
         #1;
         chk("alt_rdy_excl", {31'h0, req0_ready & req1_ready}, 32'h0);
         chk("alt_rdy_busy", {31'h0, busy & (req0_ready | req1_ready)}, 32'h0);
         if (req0_ready || req1_ready) begin
            chk($sformatf("alt_grant%0d", ng), {31'h0, req1_ready}, ng % 2);
            ng++;
         end
         @(posedge clk);
         @(negedge clk);
      end
      chk("alt_grant_count", ng, 8);
      drive(0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      repeat (6) @(negedge clk);

      // ---------------- randomized traffic against a transaction-level model ----------------
      do_reset("rnd_rst");
      pend = '{0, 0}; p_we = '{0, 0}; p_addr = '{0, 0}; p_wdata = '{0, 0};
      m_busy = 0; m_port = 0; m_err = 0; m_rdata = '0; cyc = 0; m_rsp_cyc = -1;
      for (int it = 0; it < 500; it++) begin
         @(negedge clk);
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && it < 470 && $urandom_range(0, 2) == 0) begin
               pend[p]    = 1'b1;
               p_we[p]    = ($urandom_range(0, 3) == 0);
               p_addr[p]  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
               p_wdata[p] = $urandom;
            end
         end
         drive(0, pend[0], p_we[0], p_addr[0], p_wdata[0]);
         drive(1, pend[1], p_we[1], p_addr[1], p_wdata[1]);
         #1;
         e_rsp = m_busy && (cyc == m_rsp_cyc);
         chk("rnd_rsp0_valid", {31'h0, rsp0_valid}, {31'h0, e_rsp && !m_port});
         chk("rnd_rsp1_valid", {31'h0, rsp1_valid}, {31'h0, e_rsp && m_port});
         if (e_rsp) begin
            chk("rnd_rdata", m_port ? rsp1_rdata : rsp0_rdata, m_rdata);
            chk("rnd_err", {31'h0, m_port ? rsp1_err : rsp0_err}, {31'h0, m_err});
         end
         chk("rnd_busy", {31'h0, busy}, {31'h0, m_busy});
         e_r0 = !m_busy && pend[0] && (m_ptr == 1'b0 || !pend[1]);
         e_r1 = !m_busy && pend[1] && (m_ptr == 1'b1 || !pend[0]);
         chk("rnd_ready0", {31'h0, req0_ready}, {31'h0, e_r0});
         chk("rnd_ready1", {31'h0, req1_ready}, {31'h0, e_r1});
         if (!m_busy) chk_stats("rnd");
         g = e_r1;
         hit = present(p_addr[g]);
         l = 0;
         if (e_r0 || e_r1) begin
            if (p_we[g]) begin
               l = 2; m_rdata = p_wdata[g]; m_err = 1'b0;
            end else if (hit) begin
               l = 2; m_rdata = mem_rd(p_addr[g]); m_err = 1'b0;
            end else if (MAXL == 1) begin
               l = 2; m_rdata = 32'h0; m_err = 1'b1;
            end else begin
               l = 4; m_rdata = mem_rd(p_addr[g]); m_err = 1'b0;
            end
         end
         @(posedge clk);
         cyc++;
         if (e_rsp) begin
            m_busy = 1'b0;
            m_ptr  = ~m_ptr;
         end
         if (e_r0 || e_r1) begin
            m_busy    = 1'b1;
            m_port    = g;
            m_rsp_cyc = cyc + l - 1;
            pend[g]   = 1'b0;
            if (hit) exp_hits++; else exp_misses++;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
